// File: rtl/cmp_pkg.sv
// Shared definitions for the comparison unit and the min/max range tracker.
package cmp_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : cmp_pkg

// File: rtl/comp_top.sv
// Combinational magnitude comparator: a vs b, signed or unsigned.
module comp_top #(
  parameter int W = cmp_pkg::DATA_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         is_signed_i,
  output logic         lt_o,
  output logic         et_o,
  output logic         gt_o
);

  always_comb begin
    et_o = (a_i == b_i);
    if (is_signed_i) begin
      lt_o = ($signed(a_i) < $signed(b_i));
    end else begin
      lt_o = (a_i < b_i);
    end
    gt_o = !lt_o && !et_o;
  end

endmodule : comp_top

// File: rtl/minmax_tracker.sv
// Streaming min/max tracker: collects a window of samples and reports the
// extremes, their first-occurrence indices and the sample count.
module minmax_tracker #(
  parameter int DATA_W = cmp_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val,
  output logic [CNT_W-1:0]  min_idx,
  output logic [CNT_W-1:0]  max_idx,
  output logic [CNT_W-1:0]  count
);

  import cmp_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q,     state_d;
  logic              mode_q,      mode_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic [DATA_W-1:0] min_q,       min_d;
  logic [DATA_W-1:0] max_q,       max_d;
  logic [CNT_W-1:0]  min_idx_q,   min_idx_d;
  logic [CNT_W-1:0]  max_idx_q,   max_idx_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic min_lt, min_et, min_gt;
  logic max_lt, max_et, max_gt;
  logic accept;

  comp_top #(.W(DATA_W)) u_cmp_min (
    .a_i         (in_data),
    .b_i         (min_q),
    .is_signed_i (mode_q),
    .lt_o        (min_lt),
    .et_o        (min_et),
    .gt_o        (min_gt)
  );

  comp_top #(.W(DATA_W)) u_cmp_max (
    .a_i         (in_data),
    .b_i         (max_q),
    .is_signed_i (mode_q),
    .lt_o        (max_lt),
    .et_o        (max_et),
    .gt_o        (max_gt)
  );

  // A start in RUN aborts the window, so it must also veto the sample.
  assign accept = (state_q == RUN) && in_valid && in_ready_q && !start;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = is_signed;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (start) begin
          mode_d  = is_signed;
          count_d = '0;
        end else if (accept) begin
          if (count_q == '0) begin
            min_d     = in_data;
            max_d     = in_data;
            min_idx_d = '0;
            max_idx_d = '0;
          end else begin
            if (min_lt) begin
              min_d     = in_data;
              min_idx_d = count_q;
            end
            if (max_gt) begin
              max_d     = in_data;
              max_idx_d = count_q;
            end
          end
          count_d = count_q + CNT_ONE;
          // Forced close at the all-ones count keeps the counter from wrapping.
          if (in_last || (count_d == CNT_MAX)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      count_q     <= '0;
      min_q       <= '0;
      max_q       <= '0;
      min_idx_q   <= '0;
      max_idx_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      min_q       <= min_d;
      max_q       <= max_d;
      min_idx_q   <= min_idx_d;
      max_idx_q   <= max_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign min_val   = min_q;
  assign max_val   = max_q;
  assign min_idx   = min_idx_q;
  assign max_idx   = max_idx_q;
  assign count     = count_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready_q && out_valid_q));

  a_result_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !out_ready) |=>
      $stable({out_valid_q, min_q, max_q, min_idx_q, max_idx_q, count_q}));

endmodule : minmax_tracker

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker; a second instance with a 4-bit counter covers the forced close.
module tb_minmax_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_signed, in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid;
  logic [15:0] min_val, max_val, min_idx, max_idx, count;

  logic        start2, is_signed2, in_valid2, in_last2, out_ready2;
  logic [15:0] in_data2;
  logic        in_ready2, out_valid2;
  logic [15:0] min_val2, max_val2;
  logic [3:0]  min_idx2, max_idx2, count2;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string       tag;
    logic [15:0] mn, mx, mni, mxi, cnt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  minmax_tracker #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .min_val(min_val), .max_val(max_val), .min_idx(min_idx), .max_idx(max_idx),
    .count(count)
  );

  minmax_tracker #(.DATA_W(16), .CNT_W(4)) dut_ovf (
    .clk(clk), .rst_n(rst_n), .start(start2), .is_signed(is_signed2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .min_val(min_val2), .max_val(max_val2), .min_idx(min_idx2), .max_idx(max_idx2),
    .count(count2)
  );

  // Result monitor: compares each handshaken result against the scoreboard head.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got min=%h max=%h cnt=%0d, required no result", min_val, max_val, count);
      end else begin
        e = sb.pop_front();
        total++;
        if (min_val !== e.mn) $display("FAIL %s.min_val: got %h, required %h", e.tag, min_val, e.mn);
        else passed++;
        total++;
        if (max_val !== e.mx) $display("FAIL %s.max_val: got %h, required %h", e.tag, max_val, e.mx);
        else passed++;
        total++;
        if (min_idx !== e.mni) $display("FAIL %s.min_idx: got %0d, required %0d", e.tag, min_idx, e.mni);
        else passed++;
        total++;
        if (max_idx !== e.mxi) $display("FAIL %s.max_idx: got %0d, required %0d", e.tag, max_idx, e.mxi);
        else passed++;
        total++;
        if (count !== e.cnt) $display("FAIL %s.count: got %0d, required %0d", e.tag, count, e.cnt);
        else passed++;
        $display("result %s: min=%h@%0d max=%h@%0d count=%0d", e.tag, min_val, min_idx, max_val, max_idx, count);
      end
    end
  end

  function automatic void push(input string tag, input logic [15:0] mn, input logic [15:0] mx,
                               input logic [15:0] mni, input logic [15:0] mxi, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.mn = mn; e.mx = mx; e.mni = mni; e.mxi = mxi; e.cnt = cnt;
    sb.push_back(e);
  endfunction

  function automatic bit less(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    if (sgn) return ($signed(a) < $signed(b));
    return (a < b);
  endfunction

  task automatic do_start(input logic sgn);
    start = 1'b1; is_signed = sgn;
    @(negedge clk);
    start = 1'b0; is_signed = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic finish_window(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) begin
      total++;
      $display("FAIL %s.timeout: out_valid=%b, required 1 within 20 cycles", tag, out_valid);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, min_val, max_val, min_idx, max_idx, count} !== 82'd0)
      $display("FAIL reset.outputs: got %h, required 0", {in_ready, out_valid, min_val, max_val, min_idx, max_idx, count});
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b00) $display("FAIL reset.idle: got ready/valid=%b, required 00", {in_ready, out_valid});
    else passed++;
  endtask

  task automatic test_unsigned();
    do_start(1'b0);
    total++;
    if (in_ready !== 1'b1) $display("FAIL unsigned.in_ready_after_start: got %b, required 1", in_ready);
    else passed++;
    push("unsigned", 16'd3, 16'd10, 16'd1, 16'd2, 16'd4);
    send(16'd5, 1'b0); send(16'd3, 1'b0); send(16'd10, 1'b0);
    total++;
    if (out_valid !== 1'b0) $display("FAIL unsigned.early_valid: got %b, required 0", out_valid);
    else passed++;
    send(16'd3, 1'b1);
    total++;
    if ({out_valid, in_ready} !== 2'b10) $display("FAIL unsigned.latency: got valid/ready=%b, required 10", {out_valid, in_ready});
    else passed++;
    finish_window("unsigned");
    total++;
    if ({out_valid, min_val, max_val} !== {1'b0, 16'd3, 16'd10})
      $display("FAIL unsigned.hold_after_handshake: got %h, required %h", {out_valid, min_val, max_val}, {1'b0, 16'd3, 16'd10});
    else passed++;
  endtask

  task automatic test_signed_modes();
    for (int s = 1; s >= 0; s--) begin
      if (s == 1) push("signed", 16'hFFFB, 16'h0005, 16'd2, 16'd1, 16'd4);
      else        push("unsigned_mode", 16'h0002, 16'hFFFF, 16'd3, 16'd0, 16'd4);
      do_start(s[0]);
      send(16'hFFFF, 1'b0); send(16'h0005, 1'b0); send(16'hFFFB, 1'b0); send(16'h0002, 1'b1);
      finish_window(s == 1 ? "signed" : "unsigned_mode");
    end
  endtask

  task automatic test_single();
    push("single", 16'd7, 16'd7, 16'd0, 16'd0, 16'd1);
    do_start(1'b0);
    send(16'd7, 1'b1);
    finish_window("single");
  endtask

  task automatic test_backpressure();
    logic [15:0] v [4];
    int n = 0;
    v[0] = 16'd5; v[1] = 16'd3; v[2] = 16'd10; v[3] = 16'd3;
    push("gaps", 16'd3, 16'd10, 16'd1, 16'd2, 16'd4);
    do_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      send(v[i], (i == 3));
      if (i < 3) repeat (2) @(negedge clk);
    end
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({out_valid, in_ready, min_val, max_val, min_idx, max_idx, count} !==
          {1'b1, 1'b0, 16'd3, 16'd10, 16'd1, 16'd2, 16'd4})
        $display("FAIL gaps.stall_cycle%0d: got %h, required %h", c,
                 {out_valid, in_ready, min_val, max_val, min_idx, max_idx, count},
                 {1'b1, 1'b0, 16'd3, 16'd10, 16'd1, 16'd2, 16'd4});
      else passed++;
      start = (c == 1); is_signed = (c == 1);
      @(negedge clk);
    end
    start = 1'b0; is_signed = 1'b0;
    finish_window("gaps");
  endtask

  task automatic test_restart();
    do_start(1'b0);
    send(16'd9, 1'b0); send(16'd1, 1'b0); send(16'd8, 1'b0);
    total++;
    if (count !== 16'd3) $display("FAIL restart.count_before: got %0d, required 3", count);
    else passed++;
    start = 1'b1; is_signed = 1'b1; in_valid = 1'b1; in_data = 16'h8000; in_last = 1'b0;
    @(negedge clk);
    start = 1'b0; is_signed = 1'b0; in_valid = 1'b0;
    total++;
    if ({in_ready, count} !== {1'b1, 16'd0}) $display("FAIL restart.count_cleared: got ready=%b count=%0d, required ready=1 count=0", in_ready, count);
    else passed++;
    push("restart", 16'hFFFE, 16'h0004, 16'd0, 16'd1, 16'd2);
    send(16'hFFFE, 1'b0); send(16'h0004, 1'b1);
    finish_window("restart");
  endtask

  task automatic test_async_reset();
    do_start(1'b0);
    send(16'h1234, 1'b0); send(16'h0042, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, min_val, max_val, min_idx, max_idx, count} !== 82'd0)
      $display("FAIL async_reset.outputs: got %h, required 0", {in_ready, out_valid, min_val, max_val, min_idx, max_idx, count});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, count} !== 18'd0) $display("FAIL async_reset.idle: got %h, required 0", {in_ready, out_valid, count});
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] corner [4];
    logic [15:0] d [12];
    logic [15:0] mn, mx, mni, mxi;
    bit sgn;
    int len;
    corner[0] = 16'h0000; corner[1] = 16'h7FFF; corner[2] = 16'h8000; corner[3] = 16'hFFFF;
    for (int w = 0; w < 4; w++) begin
      sgn = $urandom_range(0, 1);
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        d[i] = ($urandom_range(0, 1) == 1) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      mn = d[0]; mx = d[0]; mni = 16'd0; mxi = 16'd0;
      for (int i = 1; i < len; i++) begin
        if (less(d[i], mn, sgn)) begin mn = d[i]; mni = 16'(i); end
        if (less(mx, d[i], sgn)) begin mx = d[i]; mxi = 16'(i); end
      end
      push($sformatf("random%0d", w), mn, mx, mni, mxi, 16'(len));
      do_start(sgn);
      for (int i = 0; i < len; i++) send(d[i], (i == len - 1));
      finish_window($sformatf("random%0d", w));
    end
  endtask

  task automatic test_overflow();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      in_valid2 = 1'b1; in_last2 = 1'b0; in_data2 = 16'(100 + ((i * 7) % 15));
      @(negedge clk);
      if (i == 13) begin
        total++;
        if ({out_valid2, in_ready2} !== 2'b01) $display("FAIL overflow.before_close: got valid/ready=%b, required 01", {out_valid2, in_ready2});
        else passed++;
      end
    end
    in_valid2 = 1'b0;
    total++;
    if ({out_valid2, in_ready2, count2} !== {1'b1, 1'b0, 4'd15})
      $display("FAIL overflow.forced_done: got valid=%b ready=%b count=%0d, required valid=1 ready=0 count=15", out_valid2, in_ready2, count2);
    else passed++;
    total++;
    if ({min_val2, min_idx2, max_val2, max_idx2} !== {16'd100, 4'd0, 16'd114, 4'd2})
      $display("FAIL overflow.extremes: got min=%0d@%0d max=%0d@%0d, required min=100@0 max=114@2", min_val2, min_idx2, max_val2, max_idx2);
    else passed++;
    $display("result overflow: min=%0d@%0d max=%0d@%0d count=%0d", min_val2, min_idx2, max_val2, max_idx2, count2);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    total++;
    if (out_valid2 !== 1'b0) $display("FAIL overflow.release: got out_valid=%b, required 0", out_valid2);
    else passed++;
  endtask

  initial begin
    start = 0; is_signed = 0; in_valid = 0; in_last = 0; out_ready = 0; in_data = '0;
    start2 = 0; is_signed2 = 0; in_valid2 = 0; in_last2 = 0; out_ready2 = 0; in_data2 = '0;
    test_reset();
    test_unsigned();
    test_signed_modes();
    test_single();
    test_backpressure();
    test_restart();
    test_async_reset();
    test_random();
    test_overflow();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard.drained: got %0d pending, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule : tb_minmax_tracker
